// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
// Lets two user channels (ch0, ch1) share the single burst interface of the
// AXI HP master. Each channel has its own write and read burst port, which
// gives four request sources. One burst is served at a time, and sources
// take turns in round-robin order. The grant is held from the moment a
// request is accepted until the master's matching finish pulse.
//
// Source index: 0 = ch0_wr, 1 = ch0_rd, 2 = ch1_wr, 3 = ch1_rd.
//
// Ports:
//   mem_clk, rst            sole clock; synchronous active-high reset
//   chN_wr_burst_*          user write ports (req/len/addr/data in;
//                           data_req/finish out)
//   chN_rd_burst_*          user read ports (req/len/addr in;
//                           data_valid/data/finish out)
//   m_wr_burst_*            write command/data to and from the AXI master
//   m_rd_burst_*            read command/data to and from the AXI master
//   busy                    a burst is currently granted
//   grant_id                index of the source being served
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 32,
  parameter int LEN_BITS      = 10
) (
  input  logic                     mem_clk,
  input  logic                     rst,

  input  logic                     ch0_wr_burst_req,
  input  logic [LEN_BITS-1:0]      ch0_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     ch0_wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] ch0_wr_burst_data,
  output logic                     ch0_wr_burst_data_req,
  output logic                     ch0_wr_burst_finish,
  input  logic                     ch0_rd_burst_req,
  input  logic [LEN_BITS-1:0]      ch0_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     ch0_rd_burst_addr,
  output logic                     ch0_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] ch0_rd_burst_data,
  output logic                     ch0_rd_burst_finish,

  input  logic                     ch1_wr_burst_req,
  input  logic [LEN_BITS-1:0]      ch1_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     ch1_wr_burst_addr,
  input  logic [MEM_DATA_BITS-1:0] ch1_wr_burst_data,
  output logic                     ch1_wr_burst_data_req,
  output logic                     ch1_wr_burst_finish,
  input  logic                     ch1_rd_burst_req,
  input  logic [LEN_BITS-1:0]      ch1_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     ch1_rd_burst_addr,
  output logic                     ch1_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] ch1_rd_burst_data,
  output logic                     ch1_rd_burst_finish,

  output logic                     m_wr_burst_req,
  output logic [LEN_BITS-1:0]      m_wr_burst_len,
  output logic [ADDR_BITS-1:0]     m_wr_burst_addr,
  output logic [MEM_DATA_BITS-1:0] m_wr_burst_data,
  input  logic                     m_wr_burst_data_req,
  input  logic                     m_wr_burst_finish,
  output logic                     m_rd_burst_req,
  output logic [LEN_BITS-1:0]      m_rd_burst_len,
  output logic [ADDR_BITS-1:0]     m_rd_burst_addr,
  input  logic                     m_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] m_rd_burst_data,
  input  logic                     m_rd_burst_finish,

  output logic                     busy,
  output logic [1:0]               grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  ptr;
  logic [3:0]  req_vec;
  logic        pick_valid;
  logic [1:0]  pick_id;
  logic [1:0]  cand;
  logic        finish_match;
  logic [3:0]  sel;

  assign req_vec = {ch1_rd_burst_req, ch1_wr_burst_req,
                    ch0_rd_burst_req, ch0_wr_burst_req};

  // Round-robin pick. The loop scans the offsets from the farthest to the
  // nearest, so the requester closest to ptr overwrites any earlier
  // candidate and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = ptr;
    cand       = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req_vec[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Only the finish that matches the direction of the grant ends the
  // burst. Even source indices are writes and odd indices are reads.
  assign finish_match = grant_id[0] ? m_rd_burst_finish : m_wr_burst_finish;

  // Next-state logic. GAP is a single dead cycle. It gives the requester
  // that just finished time to drop its req before arbitration restarts.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (pick_valid) state_next = ST_BUSY;
      ST_BUSY: if (finish_match) state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State and command registers. The address and length are captured once,
  // when the request is accepted. They therefore stay fixed for the whole
  // burst, even if the requester changes its inputs.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      ptr             <= 2'd0;
      grant_id        <= 2'd0;
      busy            <= 1'b0;
      m_wr_burst_req  <= 1'b0;
      m_wr_burst_len  <= '0;
      m_wr_burst_addr <= '0;
      m_rd_burst_req  <= 1'b0;
      m_rd_burst_len  <= '0;
      m_rd_burst_addr <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && pick_valid) begin
        grant_id <= pick_id;
        ptr      <= pick_id + 2'd1;
        busy     <= 1'b1;
        if (!pick_id[0]) begin
          m_wr_burst_req  <= 1'b1;
          m_wr_burst_addr <= pick_id[1] ? ch1_wr_burst_addr : ch0_wr_burst_addr;
          m_wr_burst_len  <= pick_id[1] ? ch1_wr_burst_len  : ch0_wr_burst_len;
        end else begin
          m_rd_burst_req  <= 1'b1;
          m_rd_burst_addr <= pick_id[1] ? ch1_rd_burst_addr : ch0_rd_burst_addr;
          m_rd_burst_len  <= pick_id[1] ? ch1_rd_burst_len  : ch0_rd_burst_len;
        end
      end else if (state == ST_BUSY && finish_match) begin
        busy           <= 1'b0;
        m_wr_burst_req <= 1'b0;
        m_rd_burst_req <= 1'b0;
      end
    end
  end

  // Strobe routing. Master strobes reach only the granted source, and only
  // while busy. This keeps every user strobe low while idle, during the gap
  // and after a reset.
  assign sel = busy ? (4'b0001 << grant_id) : 4'b0000;

  assign ch0_wr_burst_data_req   = sel[0] & m_wr_burst_data_req;
  assign ch0_wr_burst_finish     = sel[0] & m_wr_burst_finish;
  assign ch0_rd_burst_data_valid = sel[1] & m_rd_burst_data_valid;
  assign ch0_rd_burst_finish     = sel[1] & m_rd_burst_finish;
  assign ch1_wr_burst_data_req   = sel[2] & m_wr_burst_data_req;
  assign ch1_wr_burst_finish     = sel[2] & m_wr_burst_finish;
  assign ch1_rd_burst_data_valid = sel[3] & m_rd_burst_data_valid;
  assign ch1_rd_burst_finish     = sel[3] & m_rd_burst_finish;

  // Read data is broadcast to both channels. Each channel uses its own
  // data_valid strobe to decide whether the data is meant for it.
  assign ch0_rd_burst_data = m_rd_burst_data;
  assign ch1_rd_burst_data = m_rd_burst_data;

  // Write data comes from the channel named by the registered grant.
  assign m_wr_burst_data = grant_id[1] ? ch1_wr_burst_data : ch0_wr_burst_data;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter
// Directed, self-checking bench for mem_burst_arbiter. The bench plays the
// part of the AXI master and of the four requesters itself. Every expected
// value below is worked out by hand from the arbiter's intended behaviour.
module tb_mem_burst_arbiter;

  logic        mem_clk = 1'b0;
  logic        rst;

  logic        ch0_wr_burst_req, ch0_rd_burst_req, ch1_wr_burst_req, ch1_rd_burst_req;
  logic [9:0]  ch0_wr_burst_len, ch0_rd_burst_len, ch1_wr_burst_len, ch1_rd_burst_len;
  logic [31:0] ch0_wr_burst_addr, ch0_rd_burst_addr, ch1_wr_burst_addr, ch1_rd_burst_addr;
  logic [63:0] ch0_wr_burst_data, ch1_wr_burst_data;
  logic        ch0_wr_burst_data_req, ch0_wr_burst_finish, ch1_wr_burst_data_req, ch1_wr_burst_finish;
  logic        ch0_rd_burst_data_valid, ch0_rd_burst_finish, ch1_rd_burst_data_valid, ch1_rd_burst_finish;
  logic [63:0] ch0_rd_burst_data, ch1_rd_burst_data;

  logic        m_wr_burst_req, m_rd_burst_req;
  logic [9:0]  m_wr_burst_len, m_rd_burst_len;
  logic [31:0] m_wr_burst_addr, m_rd_burst_addr;
  logic [63:0] m_wr_burst_data, m_rd_burst_data;
  logic        m_wr_burst_data_req, m_wr_burst_finish;
  logic        m_rd_burst_data_valid, m_rd_burst_finish;
  logic        busy;
  logic [1:0]  grant_id;

  int errors = 0;
  int checks = 0;

  logic [3:0]  fin_vec;

  assign fin_vec = {ch1_rd_burst_finish, ch1_wr_burst_finish,
                    ch0_rd_burst_finish, ch0_wr_burst_finish};

  mem_burst_arbiter #(
    .MEM_DATA_BITS(64),
    .ADDR_BITS(32),
    .LEN_BITS(10)
  ) dut (
    .mem_clk                (mem_clk),
    .rst                    (rst),
    .ch0_wr_burst_req       (ch0_wr_burst_req),
    .ch0_wr_burst_len       (ch0_wr_burst_len),
    .ch0_wr_burst_addr      (ch0_wr_burst_addr),
    .ch0_wr_burst_data      (ch0_wr_burst_data),
    .ch0_wr_burst_data_req  (ch0_wr_burst_data_req),
    .ch0_wr_burst_finish    (ch0_wr_burst_finish),
    .ch0_rd_burst_req       (ch0_rd_burst_req),
    .ch0_rd_burst_len       (ch0_rd_burst_len),
    .ch0_rd_burst_addr      (ch0_rd_burst_addr),
    .ch0_rd_burst_data_valid(ch0_rd_burst_data_valid),
    .ch0_rd_burst_data      (ch0_rd_burst_data),
    .ch0_rd_burst_finish    (ch0_rd_burst_finish),
    .ch1_wr_burst_req       (ch1_wr_burst_req),
    .ch1_wr_burst_len       (ch1_wr_burst_len),
    .ch1_wr_burst_addr      (ch1_wr_burst_addr),
    .ch1_wr_burst_data      (ch1_wr_burst_data),
    .ch1_wr_burst_data_req  (ch1_wr_burst_data_req),
    .ch1_wr_burst_finish    (ch1_wr_burst_finish),
    .ch1_rd_burst_req       (ch1_rd_burst_req),
    .ch1_rd_burst_len       (ch1_rd_burst_len),
    .ch1_rd_burst_addr      (ch1_rd_burst_addr),
    .ch1_rd_burst_data_valid(ch1_rd_burst_data_valid),
    .ch1_rd_burst_data      (ch1_rd_burst_data),
    .ch1_rd_burst_finish    (ch1_rd_burst_finish),
    .m_wr_burst_req         (m_wr_burst_req),
    .m_wr_burst_len         (m_wr_burst_len),
    .m_wr_burst_addr        (m_wr_burst_addr),
    .m_wr_burst_data        (m_wr_burst_data),
    .m_wr_burst_data_req    (m_wr_burst_data_req),
    .m_wr_burst_finish      (m_wr_burst_finish),
    .m_rd_burst_req         (m_rd_burst_req),
    .m_rd_burst_len         (m_rd_burst_len),
    .m_rd_burst_addr        (m_rd_burst_addr),
    .m_rd_burst_data_valid  (m_rd_burst_data_valid),
    .m_rd_burst_data        (m_rd_burst_data),
    .m_rd_burst_finish      (m_rd_burst_finish),
    .busy                   (busy),
    .grant_id               (grant_id)
  );

  // 100 MHz mem_clk.
  always #5 mem_clk = ~mem_clk;

  // Safety net: if the run ever stalls, report it and stop.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Moves to 2 ns after the next rising edge. Registered outputs are stable
  // by then, and inputs can be driven well away from the edge.
  task automatic cyc();
    @(posedge mem_clk);
    #2;
  endtask

  // Lets combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  // Single comparison point. It counts the check and reports any mismatch.
  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the req line of one source, selected by its source index.
  task automatic apply_req(input int idx, input logic val);
    case (idx)
      0: ch0_wr_burst_req = val;
      1: ch0_rd_burst_req = val;
      2: ch1_wr_burst_req = val;
      default: ch1_rd_burst_req = val;
    endcase
  endtask

  // Holds reset for one edge. This also returns the rr pointer to 0.
  task automatic apply_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int cnt_a;
    int cnt_b;
    logic [31:0] exp_addr [4];
    logic [9:0]  exp_len  [4];

    rst = 1'b1;
    {ch0_wr_burst_req, ch0_rd_burst_req, ch1_wr_burst_req, ch1_rd_burst_req} = 4'b0;
    ch0_wr_burst_len = '0; ch0_rd_burst_len = '0; ch1_wr_burst_len = '0; ch1_rd_burst_len = '0;
    ch0_wr_burst_addr = '0; ch0_rd_burst_addr = '0; ch1_wr_burst_addr = '0; ch1_rd_burst_addr = '0;
    ch0_wr_burst_data = '0; ch1_wr_burst_data = '0;
    m_wr_burst_data_req = 1'b0; m_wr_burst_finish = 1'b0;
    m_rd_burst_data_valid = 1'b0; m_rd_burst_finish = 1'b0; m_rd_burst_data = '0;

    // Reset state. Master strobes are driven high here to show that they
    // are gated off while idle.
    cyc();
    cyc();
    rst = 1'b0;
    m_wr_burst_data_req = 1'b1;
    m_rd_burst_data_valid = 1'b1;
    settle();
    check_output("rst_busy", 64'(busy), 64'(1'b0));
    check_output("rst_grant", 64'(grant_id), 64'(2'd0));
    check_output("rst_m_wr_req", 64'(m_wr_burst_req), 64'(1'b0));
    check_output("rst_m_rd_req", 64'(m_rd_burst_req), 64'(1'b0));
    check_output("rst_m_wr_addr", 64'(m_wr_burst_addr), 64'(32'h0));
    check_output("rst_m_rd_len", 64'(m_rd_burst_len), 64'(10'd0));
    check_output("rst_ch0_wr_dreq", 64'(ch0_wr_burst_data_req), 64'(1'b0));
    check_output("rst_ch0_rd_valid", 64'(ch0_rd_burst_data_valid), 64'(1'b0));
    m_wr_burst_data_req = 1'b0;
    m_rd_burst_data_valid = 1'b0;

    // Single ch0 write: len 16 at address 0x100.
    cyc();
    ch0_wr_burst_req = 1'b1;
    ch0_wr_burst_len = 10'd16;
    ch0_wr_burst_addr = 32'h100;
    settle();
    check_output("t1_m_wr_req_before", 64'(m_wr_burst_req), 64'(1'b0));
    cyc();
    check_output("t1_m_wr_req", 64'(m_wr_burst_req), 64'(1'b1));
    check_output("t1_m_wr_addr", 64'(m_wr_burst_addr), 64'(32'h100));
    check_output("t1_m_wr_len", 64'(m_wr_burst_len), 64'(10'd16));
    check_output("t1_busy", 64'(busy), 64'(1'b1));
    check_output("t1_grant", 64'(grant_id), 64'(2'd0));
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      m_wr_burst_data_req = 1'b1;
      ch0_wr_burst_data = 64'hD000 + 64'(i);
      ch1_wr_burst_data = 64'hE000 + 64'(i);
      settle();
      if (ch0_wr_burst_data_req) cnt_a++;
      if (ch1_wr_burst_data_req || ch0_rd_burst_data_valid || ch1_rd_burst_data_valid) cnt_b++;
      check_output("t1_wr_data_mux", m_wr_burst_data, 64'hD000 + 64'(i));
      cyc();
    end
    m_wr_burst_data_req = 1'b0;
    m_wr_burst_finish = 1'b1;
    settle();
    check_output("t1_fin_vec", 64'(fin_vec), 64'(4'b0001));
    check_output("t1_ch0_pulses", 64'(cnt_a), 64'd16);
    check_output("t1_other_pulses", 64'(cnt_b), 64'd0);
    cyc();
    m_wr_burst_finish = 1'b0;
    ch0_wr_burst_req = 1'b0;
    check_output("t1_busy_after", 64'(busy), 64'(1'b0));
    check_output("t1_m_wr_req_after", 64'(m_wr_burst_req), 64'(1'b0));

    // All four sources request together after reset. They must be served
    // in the order 0,1,2,3 and then 0 again, each 3 cycles after the
    // previous finish.
    apply_reset();
    exp_addr[0] = 32'h10; exp_len[0] = 10'd1;
    exp_addr[1] = 32'h20; exp_len[1] = 10'd2;
    exp_addr[2] = 32'h30; exp_len[2] = 10'd3;
    exp_addr[3] = 32'h40; exp_len[3] = 10'd4;
    ch0_wr_burst_addr = exp_addr[0]; ch0_wr_burst_len = exp_len[0];
    ch0_rd_burst_addr = exp_addr[1]; ch0_rd_burst_len = exp_len[1];
    ch1_wr_burst_addr = exp_addr[2]; ch1_wr_burst_len = exp_len[2];
    ch1_rd_burst_addr = exp_addr[3]; ch1_rd_burst_len = exp_len[3];
    {ch0_wr_burst_req, ch0_rd_burst_req, ch1_wr_burst_req, ch1_rd_burst_req} = 4'b1111;
    cyc();
    for (int g = 0; g < 4; g++) begin
      check_output("t2_grant", 64'(grant_id), 64'(g));
      check_output("t2_busy", 64'(busy), 64'(1'b1));
      if (g % 2 == 0) begin
        check_output("t2_m_wr_req", 64'(m_wr_burst_req), 64'(1'b1));
        check_output("t2_m_wr_addr", 64'(m_wr_burst_addr), 64'(exp_addr[g]));
        check_output("t2_m_wr_len", 64'(m_wr_burst_len), 64'(exp_len[g]));
      end else begin
        check_output("t2_m_rd_req", 64'(m_rd_burst_req), 64'(1'b1));
        check_output("t2_m_rd_addr", 64'(m_rd_burst_addr), 64'(exp_addr[g]));
        check_output("t2_m_rd_len", 64'(m_rd_burst_len), 64'(exp_len[g]));
      end
      if (g == 3) ch0_wr_burst_req = 1'b1;
      cyc();
      if (g % 2 == 0) m_wr_burst_finish = 1'b1;
      else m_rd_burst_finish = 1'b1;
      settle();
      check_output("t2_fin_vec", 64'(fin_vec), 64'(4'b0001 << g));
      cyc();
      m_wr_burst_finish = 1'b0;
      m_rd_burst_finish = 1'b0;
      apply_req(g, 1'b0);
      check_output("t2_busy_f1", 64'(busy), 64'(1'b0));
      cyc();
      check_output("t2_busy_f2", 64'(busy), 64'(1'b0));
      cyc();
      check_output("t2_busy_f3", 64'(busy), 64'(1'b1));
    end
    check_output("t2_regrant0", 64'(grant_id), 64'(2'd0));
    m_wr_burst_finish = 1'b1;
    cyc();
    m_wr_burst_finish = 1'b0;
    ch0_wr_burst_req = 1'b0;

    // ch1 read of 8 words. Valid strobes must reach only ch1, while the
    // read data appears on both buses.
    apply_reset();
    ch1_rd_burst_req = 1'b1;
    ch1_rd_burst_len = 10'd8;
    ch1_rd_burst_addr = 32'h800;
    cyc();
    check_output("t3_grant", 64'(grant_id), 64'(2'd3));
    check_output("t3_m_rd_addr", 64'(m_rd_burst_addr), 64'(32'h800));
    check_output("t3_m_rd_len", 64'(m_rd_burst_len), 64'(10'd8));
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      m_rd_burst_data_valid = 1'b1;
      m_rd_burst_data = 64'hA0 + 64'(i);
      settle();
      if (ch1_rd_burst_data_valid) cnt_a++;
      if (ch0_rd_burst_data_valid) cnt_b++;
      check_output("t3_ch0_rd_data", ch0_rd_burst_data, 64'hA0 + 64'(i));
      check_output("t3_ch1_rd_data", ch1_rd_burst_data, 64'hA0 + 64'(i));
      cyc();
    end
    m_rd_burst_data_valid = 1'b0;
    m_rd_burst_finish = 1'b1;
    settle();
    check_output("t3_fin_vec", 64'(fin_vec), 64'(4'b1000));
    check_output("t3_ch1_valids", 64'(cnt_a), 64'd8);
    check_output("t3_ch0_valids", 64'(cnt_b), 64'd0);
    cyc();
    m_rd_burst_finish = 1'b0;
    ch1_rd_burst_req = 1'b0;

    // ch0 read. Its address changes mid-burst and a stray write finish is
    // injected; the latched address must hold and the grant must stay.
    apply_reset();
    ch0_rd_burst_req = 1'b1;
    ch0_rd_burst_len = 10'd4;
    ch0_rd_burst_addr = 32'h200;
    cyc();
    check_output("t4_grant", 64'(grant_id), 64'(2'd1));
    ch0_rd_burst_addr = 32'h999;
    m_wr_burst_finish = 1'b1;
    settle();
    check_output("t4_stray_fin_vec", 64'(fin_vec), 64'(4'b0000));
    cyc();
    m_wr_burst_finish = 1'b0;
    check_output("t4_busy", 64'(busy), 64'(1'b1));
    check_output("t4_grant_held", 64'(grant_id), 64'(2'd1));
    check_output("t4_m_rd_addr", 64'(m_rd_burst_addr), 64'(32'h200));
    check_output("t4_m_rd_req", 64'(m_rd_burst_req), 64'(1'b1));
    m_rd_burst_finish = 1'b1;
    settle();
    check_output("t4_fin_vec", 64'(fin_vec), 64'(4'b0010));
    cyc();
    m_rd_burst_finish = 1'b0;
    ch0_rd_burst_req = 1'b0;
    check_output("t4_busy_after", 64'(busy), 64'(1'b0));
    check_output("t4_m_rd_req_after", 64'(m_rd_burst_req), 64'(1'b0));

    // Reset arrives after 3 of 16 write data pulses. The burst is dropped
    // without a finish, and the still-held request is then served again.
    apply_reset();
    ch1_wr_burst_req = 1'b1;
    ch1_wr_burst_len = 10'd16;
    ch1_wr_burst_addr = 32'h300;
    cyc();
    check_output("t5_grant", 64'(grant_id), 64'(2'd2));
    for (int i = 0; i < 3; i++) begin
      m_wr_burst_data_req = 1'b1;
      cyc();
    end
    m_wr_burst_data_req = 1'b0;
    rst = 1'b1;
    cyc();
    check_output("t5_rst_busy", 64'(busy), 64'(1'b0));
    check_output("t5_rst_m_wr_req", 64'(m_wr_burst_req), 64'(1'b0));
    check_output("t5_rst_grant", 64'(grant_id), 64'(2'd0));
    rst = 1'b0;
    m_wr_burst_finish = 1'b1;
    settle();
    check_output("t5_no_fin", 64'(fin_vec), 64'(4'b0000));
    cyc();
    m_wr_burst_finish = 1'b0;
    check_output("t5_regrant_busy", 64'(busy), 64'(1'b1));
    check_output("t5_regrant_id", 64'(grant_id), 64'(2'd2));
    check_output("t5_regrant_addr", 64'(m_wr_burst_addr), 64'(32'h300));
    m_wr_burst_finish = 1'b1;
    settle();
    check_output("t5_fin_vec", 64'(fin_vec), 64'(4'b0100));
    cyc();
    m_wr_burst_finish = 1'b0;
    ch1_wr_burst_req = 1'b0;

    // ch0_wr holds its request continuously, and ch1_rd asks mid-burst.
    // ch1_rd must be served before ch0_wr gets the bus again.
    apply_reset();
    ch0_wr_burst_req = 1'b1;
    ch0_wr_burst_addr = 32'h500;
    ch0_wr_burst_len = 10'd2;
    cyc();
    check_output("t6_first_grant", 64'(grant_id), 64'(2'd0));
    ch1_rd_burst_req = 1'b1;
    ch1_rd_burst_addr = 32'h600;
    ch1_rd_burst_len = 10'd2;
    cyc();
    m_wr_burst_finish = 1'b1;
    settle();
    check_output("t6_wr_fin", 64'(fin_vec), 64'(4'b0001));
    cyc();
    m_wr_burst_finish = 1'b0;
    cyc();
    cyc();
    check_output("t6_second_grant", 64'(grant_id), 64'(2'd3));
    check_output("t6_m_rd_req", 64'(m_rd_burst_req), 64'(1'b1));
    check_output("t6_m_wr_req", 64'(m_wr_burst_req), 64'(1'b0));
    check_output("t6_m_rd_addr", 64'(m_rd_burst_addr), 64'(32'h600));
    m_rd_burst_finish = 1'b1;
    cyc();
    m_rd_burst_finish = 1'b0;
    ch1_rd_burst_req = 1'b0;
    cyc();
    cyc();
    check_output("t6_third_grant", 64'(grant_id), 64'(2'd0));
    check_output("t6_m_wr_req_again", 64'(m_wr_burst_req), 64'(1'b1));
    m_wr_burst_finish = 1'b1;
    cyc();
    m_wr_burst_finish = 1'b0;
    ch0_wr_burst_req = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
